// File: rtl/uart_byte_tx.sv
// 8N1 byte serialiser: accepts a one-cycle send_en pulse, shifts the byte out LSB-first, then pulses tx_done.
// Define UART_TX_PARITY_EN to insert a parity bit (sense set by PARITY_ODD) between D7 and the stop bit.
module uart_byte_tx #(
    parameter int CLK_FREQ   = 50000000,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       send_en,
    input  logic [7:0] data_byte,
    input  logic [2:0] baud_set,
    output logic       uart_tx,
    output logic       tx_done,
    output logic       uart_state
);

    localparam logic [12:0] DIV_9600   = 13'(CLK_FREQ / 9600);
    localparam logic [12:0] DIV_19200  = 13'(CLK_FREQ / 19200);
    localparam logic [12:0] DIV_38400  = 13'(CLK_FREQ / 38400);
    localparam logic [12:0] DIV_57600  = 13'(CLK_FREQ / 57600);
    localparam logic [12:0] DIV_115200 = 13'(CLK_FREQ / 115200);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t      r_state;
    logic [12:0] r_cnt;
    logic [12:0] r_div;
    logic [3:0]  r_idx;
    logic [7:0]  r_byte;
    logic [12:0] w_div;
    logic        w_tick;

    always_comb begin
        w_div = DIV_9600;
        case (baud_set)
            3'd1:    w_div = DIV_19200;
            3'd2:    w_div = DIV_38400;
            3'd3:    w_div = DIV_57600;
            3'd4:    w_div = DIV_115200;
            default: w_div = DIV_9600;
        endcase
    end

    // Last clock of the current bit period.
    assign w_tick = (r_cnt == r_div - 13'd1);

`ifndef UART_TX_PARITY_EN
    logic w_unused_parity;
    assign w_unused_parity = PARITY_ODD[0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_div      <= '0;
            r_idx      <= '0;
            r_byte     <= '0;
            uart_tx    <= 1'b1;
            tx_done    <= 1'b0;
            uart_state <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (r_state == S_IDLE) begin
                // Inputs are captured here so the frame is immune to later bus changes.
                if (send_en) begin
                    r_byte     <= data_byte;
                    r_div      <= w_div;
                    r_cnt      <= '0;
                    r_idx      <= '0;
                    uart_tx    <= 1'b0;
                    uart_state <= 1'b1;
                    r_state    <= S_START;
                end
            end else begin
                r_cnt <= w_tick ? 13'd0 : r_cnt + 13'd1;
                if (w_tick) begin
                    case (r_state)
                        S_START: begin
                            uart_tx <= r_byte[0];
                            r_idx   <= '0;
                            r_state <= S_DATA;
                        end
                        S_DATA: begin
                            if (r_idx == 4'd7) begin
`ifdef UART_TX_PARITY_EN
                                uart_tx <= (^r_byte) ^ PARITY_ODD[0];
                                r_state <= S_PAR;
`else
                                uart_tx <= 1'b1;
                                r_state <= S_STOP;
`endif
                            end else begin
                                uart_tx <= r_byte[r_idx[2:0] + 3'd1];
                                r_idx   <= r_idx + 4'd1;
                            end
                        end
`ifdef UART_TX_PARITY_EN
                        S_PAR: begin
                            uart_tx <= 1'b1;
                            r_state <= S_STOP;
                        end
`endif
                        S_STOP: begin
                            uart_tx    <= 1'b1;
                            uart_state <= 1'b0;
                            tx_done    <= 1'b1;
                            r_state    <= S_IDLE;
                        end
                        default: begin
                            uart_tx    <= 1'b1;
                            uart_state <= 1'b0;
                            r_state    <= S_IDLE;
                        end
                    endcase
                end
            end
        end
    end

endmodule
